// File: rtl/core_inst_pkg.sv
// core_inst_pkg
// Shared definitions for the core instruction word and its tile sequencer:
//   - array / memory geometry localparams
//   - bit positions and field slices of the 64-bit core instruction word
//   - IDLE_WORD: every memory deselected, no strobes active
//   - sequencer state and drain sub-step enums
//   - ctrl_t: named control strobes consumed by core_inst_pack
// No ports (package).
package core_inst_pkg;

    localparam int ROW      = 8;
    localparam int COL      = 8;
    localparam int ADDR_W   = 11;
    localparam int L0_DEPTH = 64;
    localparam int LEN_W    = 7;
    localparam int INST_W   = 64;

    // Instruction word bit positions
    localparam int B_LOAD        = 0;
    localparam int B_EXECUTE     = 1;
    localparam int B_L0_WR       = 2;
    localparam int B_L0_RD       = 3;
    localparam int B_IFIFO_RD    = 4;
    localparam int B_IFIFO_WR    = 5;
    localparam int B_OFIFO_RD    = 6;
    localparam int A_XMEM_LSB    = 7;
    localparam int A_XMEM_MSB    = 17;
    localparam int B_WEN_XMEM    = 18;
    localparam int B_CEN_XMEM    = 19;
    localparam int A_PMEM_LSB    = 20;
    localparam int A_PMEM_MSB    = 30;
    localparam int B_WEN_PMEM    = 31;
    localparam int B_CEN_PMEM    = 32;
    localparam int B_ACC         = 33;
    localparam int B_PASSTHROUGH = 34;
    localparam int B_REN_PMEM    = 35;
    localparam int B_OS_MODE     = 36;   // 0: weight stationary
    localparam int B_RECALL      = 37;   // psum recall, unused here
    localparam int B_RECALL_ACC  = 38;   // psum recall accumulate, unused here
    localparam int B_PASS_PSUM   = 39;
    localparam int B_DEBUG       = 63;

    // CEN_xmem, WEN_xmem, CEN_pmem, WEN_pmem high; everything else low.
    localparam logic [INST_W-1:0] IDLE_WORD = 64'h0000_0001_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_FETCH  = 3'd1,
        S_W_LOAD   = 3'd2,
        S_W_SETTLE = 3'd3,
        S_X_FETCH  = 3'd4,
        S_X_EXEC   = 3'd5,
        S_DRAIN    = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    // What the current DRAIN cycle is doing for vector r_idx.
    typedef enum logic [1:0] {
        D_STALL = 2'd0,
        D_RD    = 2'd1,
        D_WR    = 2'd2
    } drain_op_t;

    // Raw levels; cen/wen are active-low exactly as they sit in the word.
    typedef struct packed {
        logic load;
        logic execute;
        logic l0_wr;
        logic l0_rd;
        logic ofifo_rd;
        logic cen_xmem;
        logic wen_xmem;
        logic cen_pmem;
        logic wen_pmem;
        logic ren_pmem;
        logic acc;
        logic passthrough;
    } ctrl_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] n);
        return (n > LEN_W'(L0_DEPTH)) ? LEN_W'(L0_DEPTH) : n;
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if
// Tile request / status bundle between a requester and core_sequencer.
//   start       requester -> seq  tile request
//   w_base      requester -> seq  xmem address of kernel row 0
//   x_base      requester -> seq  xmem address of activation vector 0
//   p_base      requester -> seq  pmem address of psum vector 0
//   n_vec       requester -> seq  activation vector count
//   accumulate  requester -> seq  1: psum += ofifo, 0: psum = ofifo
//   ofifo_valid core      -> seq  OFIFO holds a readable vector
//   busy/done   seq -> requester  status
//   inst        seq -> core       registered instruction word
// Handshake: start is a single-sided request, accepted on any rising clock
// edge where busy is low; the config fields are captured on that same edge.
// A start seen while busy is high (including the DONE cycle) is dropped.
interface core_sequencer_if;
    import core_inst_pkg::*;

    logic                start;
    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   x_base;
    logic [ADDR_W-1:0]   p_base;
    logic [LEN_W-1:0]    n_vec;
    logic                accumulate;
    logic                ofifo_valid;
    logic                busy;
    logic                done;
    logic [INST_W-1:0]   inst;

    modport master (
        output start, w_base, x_base, p_base, n_vec, accumulate, ofifo_valid,
        input  busy, done, inst
    );

    modport slave (
        input  start, w_base, x_base, p_base, n_vec, accumulate, ofifo_valid,
        output busy, done, inst
    );

endinterface

// File: rtl/core_inst_pack.sv
// core_inst_pack
// Combinational encoder: named control strobes plus the xmem/pmem addresses
// into the 64-bit core instruction word. Mode, recall, pass_psum, ififo and
// debug bits are tied low.
//   i_ctrl    control strobes (ctrl_t)
//   i_a_xmem  xmem address
//   i_a_pmem  pmem address
//   o_inst    instruction word
module core_inst_pack
    import core_inst_pkg::*;
(
    input  ctrl_t              i_ctrl,
    input  logic [ADDR_W-1:0]  i_a_xmem,
    input  logic [ADDR_W-1:0]  i_a_pmem,
    output logic [INST_W-1:0]  o_inst
);

    always_comb begin
        o_inst                          = '0;
        o_inst[B_LOAD]                  = i_ctrl.load;
        o_inst[B_EXECUTE]               = i_ctrl.execute;
        o_inst[B_L0_WR]                 = i_ctrl.l0_wr;
        o_inst[B_L0_RD]                 = i_ctrl.l0_rd;
        o_inst[B_OFIFO_RD]              = i_ctrl.ofifo_rd;
        o_inst[A_XMEM_MSB:A_XMEM_LSB]   = i_a_xmem;
        o_inst[B_WEN_XMEM]              = i_ctrl.wen_xmem;
        o_inst[B_CEN_XMEM]              = i_ctrl.cen_xmem;
        o_inst[A_PMEM_MSB:A_PMEM_LSB]   = i_a_pmem;
        o_inst[B_WEN_PMEM]              = i_ctrl.wen_pmem;
        o_inst[B_CEN_PMEM]              = i_ctrl.cen_pmem;
        o_inst[B_ACC]                   = i_ctrl.acc;
        o_inst[B_PASSTHROUGH]           = i_ctrl.passthrough;
        o_inst[B_REN_PMEM]              = i_ctrl.ren_pmem;
    end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer
// Drives the core instruction bus for one weight-stationary tile:
// fetch kernel rows into L0, shift them into the PE array, let them settle,
// fetch and execute n_vec activation vectors, then drain the OFIFO into
// psum SRAM (overwrite or read-modify-write).
//   clk          clock
//   reset        synchronous, active-high
//   bus          core_sequencer_if.slave (start/config/ofifo_valid in,
//                busy/done/inst out)
//   o_dbg_state  current FSM state
// The instruction word is registered and is computed from the *next* state,
// so the word belonging to a state appears in the same cycle as that state.
module core_sequencer
    import core_inst_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    core_sequencer_if.slave   bus,
    output state_t            o_dbg_state
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t             r_state, w_state_nxt;
    drain_op_t          r_op, w_op_nxt, w_vec_op;
    logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;      // cycles left in phase after this one
    logic [LEN_W-1:0]   r_idx, w_idx_nxt;      // fetch row/vector or drain vector
    logic [ADDR_W-1:0]  r_w_base, r_x_base, r_p_base;
    logic [LEN_W-1:0]   r_n;
    logic               r_acc;
    logic [INST_W-1:0]  r_inst, w_inst;
    logic               w_accept;
    logic [LEN_W-1:0]   w_n_in;
    logic [ADDR_W-1:0]  w_w_base_eff;
    logic [ADDR_W-1:0]  w_a_xmem, w_a_pmem;
    ctrl_t              w_ctrl;

    assign w_accept     = (r_state == S_IDLE) && bus.start;
    assign w_n_in       = clamp_len(bus.n_vec);
    // The first W_FETCH word is built on the accepting edge, before r_w_base holds it.
    assign w_w_base_eff = (r_state == S_IDLE) ? bus.w_base : r_w_base;
    // A vector's first drain cycle only goes out when the OFIFO has data.
    assign w_vec_op     = !bus.ofifo_valid ? D_STALL : (r_acc ? D_RD : D_WR);

    // Next state and phase counters
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_op_nxt    = r_op;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_idx_nxt = '0;
                    w_op_nxt  = D_STALL;
                    if (w_n_in == '0) begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_W_FETCH;
                        w_cnt_nxt   = LEN_W'(ROW);      // ROW+1 cycles
                    end
                end
            end
            S_W_FETCH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_W_LOAD;
                    w_cnt_nxt   = LEN_W'(ROW - 1);
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - ONE;
                    w_idx_nxt = r_idx + ONE;
                end
            end
            S_W_LOAD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_W_SETTLE;
                    w_cnt_nxt   = LEN_W'(COL - 1);
                end else begin
                    w_cnt_nxt = r_cnt - ONE;
                end
            end
            S_W_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_X_FETCH;
                    w_cnt_nxt   = r_n;                  // n_vec+1 cycles
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - ONE;
                end
            end
            S_X_FETCH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_X_EXEC;
                    w_cnt_nxt   = r_n - ONE;
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - ONE;
                    w_idx_nxt = r_idx + ONE;
                end
            end
            S_X_EXEC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DRAIN;
                    w_idx_nxt   = '0;
                    w_op_nxt    = w_vec_op;
                end else begin
                    w_cnt_nxt = r_cnt - ONE;
                end
            end
            S_DRAIN: begin
                case (r_op)
                    D_RD: w_op_nxt = D_WR;
                    D_WR: begin
                        if ((r_idx + ONE) == r_n) begin
                            w_state_nxt = S_DONE;
                            w_op_nxt    = D_STALL;
                            w_idx_nxt   = '0;
                        end else begin
                            w_idx_nxt = r_idx + ONE;
                            w_op_nxt  = w_vec_op;
                        end
                    end
                    default: w_op_nxt = w_vec_op;       // retry the stalled vector
                endcase
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Strobes for the word that goes out with the next state
    always_comb begin
        w_ctrl          = '0;
        w_ctrl.cen_xmem = 1'b1;
        w_ctrl.wen_xmem = 1'b1;
        w_ctrl.cen_pmem = 1'b1;
        w_ctrl.wen_pmem = 1'b1;
        w_a_xmem        = '0;
        w_a_pmem        = '0;
        case (w_state_nxt)
            S_W_FETCH: begin
                // xmem read latency is 1, so the L0 write trails by a cycle
                if (w_idx_nxt < LEN_W'(ROW)) begin
                    w_ctrl.cen_xmem = 1'b0;
                    w_a_xmem        = w_w_base_eff + ADDR_W'(w_idx_nxt);
                end
                w_ctrl.l0_wr = (w_idx_nxt != '0);
            end
            S_W_LOAD: begin
                w_ctrl.load  = 1'b1;
                w_ctrl.l0_rd = 1'b1;
            end
            S_X_FETCH: begin
                if (w_idx_nxt < r_n) begin
                    w_ctrl.cen_xmem = 1'b0;
                    w_a_xmem        = r_x_base + ADDR_W'(w_idx_nxt);
                end
                w_ctrl.l0_wr = (w_idx_nxt != '0);
            end
            S_X_EXEC: begin
                w_ctrl.execute = 1'b1;
                w_ctrl.l0_rd   = 1'b1;
            end
            S_DRAIN: begin
                case (w_op_nxt)
                    D_RD: begin
                        w_ctrl.cen_pmem = 1'b0;
                        w_ctrl.ren_pmem = 1'b1;
                        w_a_pmem        = r_p_base + ADDR_W'(w_idx_nxt);
                    end
                    D_WR: begin
                        w_ctrl.cen_pmem    = 1'b0;
                        w_ctrl.wen_pmem    = 1'b0;
                        w_ctrl.ofifo_rd    = 1'b1;
                        w_ctrl.acc         = r_acc;
                        w_ctrl.passthrough = !r_acc;
                        w_a_pmem           = r_p_base + ADDR_W'(w_idx_nxt);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    core_inst_pack u_pack (
        .i_ctrl   (w_ctrl),
        .i_a_xmem (w_a_xmem),
        .i_a_pmem (w_a_pmem),
        .o_inst   (w_inst)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_op     <= D_STALL;
            r_inst   <= IDLE_WORD;
            r_w_base <= '0;
            r_x_base <= '0;
            r_p_base <= '0;
            r_n      <= '0;
            r_acc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_op    <= w_op_nxt;
            r_inst  <= w_inst;
            if (w_accept) begin
                r_w_base <= bus.w_base;
                r_x_base <= bus.x_base;
                r_p_base <= bus.p_base;
                r_n      <= w_n_in;
                r_acc    <= bus.accumulate;
            end
        end
    end

    assign bus.inst    = r_inst;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer
// Directed bench for core_sequencer. A negedge monitor decodes the
// instruction stream of the current tile into observation queues/counters;
// each test task launches a tile and compares those against hand-computed
// expectations.
module tb_core_sequencer;
    import core_inst_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    core_sequencer_if bus ();
    state_t dbg_state;

    core_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- monitor ----------------
    logic             mon_en = 1'b0;
    logic [63:0]      mw;
    int               cyc, done_cyc, done_cnt, busy_cnt;
    int               l0wr_cnt, l0rd_cnt, load_cnt, exec_cnt, ofrd_cnt, fixed_bad;
    logic [ADDR_W-1:0] xrd_q[$];
    logic [15:0]      pm_q[$];   // {ren, wr, acc, pass, ofifo_rd, addr}
    logic [63:0]      inst_q[$];

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            mw = bus.inst;
            if (mw[B_CEN_XMEM] == 1'b0) xrd_q.push_back(mw[A_XMEM_MSB:A_XMEM_LSB]);
            if (mw[B_CEN_PMEM] == 1'b0)
                pm_q.push_back({mw[B_REN_PMEM], ~mw[B_WEN_PMEM], mw[B_ACC],
                                mw[B_PASSTHROUGH], mw[B_OFIFO_RD], mw[A_PMEM_MSB:A_PMEM_LSB]});
            if (mw[B_L0_WR])    l0wr_cnt++;
            if (mw[B_L0_RD])    l0rd_cnt++;
            if (mw[B_LOAD])     load_cnt++;
            if (mw[B_EXECUTE])  exec_cnt++;
            if (mw[B_OFIFO_RD]) ofrd_cnt++;
            if (mw[39:36] != 4'b0 || mw[B_DEBUG]) fixed_bad++;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            inst_q.push_back(mw);
        end
    end

    task automatic mon_clear();
        cyc = 0; done_cyc = -1; done_cnt = 0; busy_cnt = 0;
        l0wr_cnt = 0; l0rd_cnt = 0; load_cnt = 0; exec_cnt = 0; ofrd_cnt = 0; fixed_bad = 0;
        xrd_q.delete(); pm_q.delete(); inst_q.delete();
    endtask

    function automatic logic [15:0] pm_enc(input logic ren, wr, acc, pass, ofr,
                                           input logic [ADDR_W-1:0] a);
        return {ren, wr, acc, pass, ofr, a};
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Presents a tile request for exactly one rising edge (edge T), then
    // scrambles the config inputs to show they are ignored. On return the
    // bench sits in cycle T+1's low phase is next; the monitor counts cycle 1
    // at the first negedge after T.
    task automatic launch(input logic [ADDR_W-1:0] wb, xb, pb,
                          input logic [LEN_W-1:0] n, input logic acc);
        @(negedge clk);
        bus.w_base = wb; bus.x_base = xb; bus.p_base = pb;
        bus.n_vec = n; bus.accumulate = acc; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.w_base = ~wb; bus.x_base = ~xb; bus.p_base = ~pb;
        bus.n_vec = 7'd5; bus.accumulate = ~acc;
        mon_clear();
        mon_en = 1'b1;
    endtask

    task automatic run_to_idle(input int max_cyc);
        int k = 0;
        while (!(done_cnt > 0 && !bus.busy) && k < max_cyc) begin
            step();
            k++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (bus.inst !== IDLE_WORD || bus.busy !== 1'b0 || bus.done !== 1'b0 || dbg_state !== S_IDLE) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: inst=%h busy=%b done=%b state=%0d, expected inst=%h busy=0 done=0 state=0",
                         i, bus.inst, bus.busy, bus.done, dbg_state, IDLE_WORD);
            end
        end
    endtask

    task automatic test_passthrough();
        logic [ADDR_W-1:0] exp_x[$];
        logic [15:0]       exp_p[$];
        int nbad;
        launch(11'h010, 11'h100, 11'h200, 7'd4, 1'b0);
        run_to_idle(100);
        mon_en = 1'b0;
        for (int i = 0; i < 8; i++) exp_x.push_back(11'h010 + 11'(i));
        for (int i = 0; i < 4; i++) exp_x.push_back(11'h100 + 11'(i));
        for (int i = 0; i < 4; i++) exp_p.push_back(pm_enc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'h200 + 11'(i)));

        checks++; if (done_cyc != 39) begin errors++; $display("FAIL pass_done_cycle: got %0d expected 39", done_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL pass_done_count: got %0d expected 1", done_cnt); end
        checks++; if (busy_cnt != 39) begin errors++; $display("FAIL pass_busy_cycles: got %0d expected 39", busy_cnt); end
        nbad = 0;
        if (xrd_q.size() != exp_x.size()) nbad++;
        else foreach (exp_x[i]) if (xrd_q[i] !== exp_x[i]) nbad++;
        checks++; if (nbad != 0) begin errors++; $display("FAIL pass_xmem_addr: %0d reads, %0d wrong, expected 12 reads", xrd_q.size(), nbad); end
        nbad = 0;
        if (pm_q.size() != exp_p.size()) nbad++;
        else foreach (exp_p[i]) if (pm_q[i] !== exp_p[i]) nbad++;
        checks++; if (nbad != 0) begin errors++; $display("FAIL pass_pmem_ops: %0d ops, %0d wrong, expected 4 ops", pm_q.size(), nbad); end
        checks++; if (l0wr_cnt != 12) begin errors++; $display("FAIL pass_l0_wr: got %0d expected 12", l0wr_cnt); end
        checks++; if (l0rd_cnt != 12) begin errors++; $display("FAIL pass_l0_rd: got %0d expected 12", l0rd_cnt); end
        checks++; if (load_cnt != 8) begin errors++; $display("FAIL pass_load: got %0d expected 8", load_cnt); end
        checks++; if (exec_cnt != 4) begin errors++; $display("FAIL pass_execute: got %0d expected 4", exec_cnt); end
        checks++; if (ofrd_cnt != 4) begin errors++; $display("FAIL pass_ofifo_rd: got %0d expected 4", ofrd_cnt); end
        checks++; if (fixed_bad != 0) begin errors++; $display("FAIL pass_fixed_bits: %0d words with bits 36-39/63 set, expected 0", fixed_bad); end
        // W_SETTLE occupies cycles 18..25 and must carry the idle word
        checks++; if (inst_q.size() < 25 || inst_q[17] !== IDLE_WORD || inst_q[24] !== IDLE_WORD) begin
            errors++; $display("FAIL pass_settle_idle: settle words not idle, expected %h", IDLE_WORD); end
    endtask

    task automatic test_accumulate();
        logic [15:0] exp_p[$];
        int nbad;
        launch(11'h010, 11'h100, 11'h200, 7'd4, 1'b1);
        run_to_idle(100);
        mon_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_p.push_back(pm_enc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h200 + 11'(i)));
            exp_p.push_back(pm_enc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'h200 + 11'(i)));
        end
        checks++; if (done_cyc != 43) begin errors++; $display("FAIL acc_done_cycle: got %0d expected 43", done_cyc); end
        nbad = 0;
        if (pm_q.size() != exp_p.size()) nbad++;
        else foreach (exp_p[i]) if (pm_q[i] !== exp_p[i]) nbad++;
        checks++; if (nbad != 0) begin errors++; $display("FAIL acc_pmem_ops: %0d ops, %0d wrong, expected 8 ops", pm_q.size(), nbad); end
        // RD for vector 0 at cycle 35, its WR at cycle 36
        checks++; if (inst_q.size() < 36 || inst_q[34][B_REN_PMEM] !== 1'b1 || inst_q[35][B_ACC] !== 1'b1) begin
            errors++; $display("FAIL acc_rd_then_wr: vector 0 RD/WR not on cycles 35/36"); end
        checks++; if (ofrd_cnt != 4) begin errors++; $display("FAIL acc_ofifo_rd: got %0d expected 4", ofrd_cnt); end
    endtask

    task automatic test_drain_stall();
        int nbad;
        launch(11'h010, 11'h100, 11'h200, 7'd4, 1'b0);
        repeat (34) step();           // now in cycle 34 (last X_EXEC)
        bus.ofifo_valid = 1'b0;       // seen on the edges opening cycles 35..39
        repeat (5) step();
        bus.ofifo_valid = 1'b1;
        run_to_idle(100);
        mon_en = 1'b0;
        nbad = 0;
        for (int i = 34; i < 39; i++) if (i >= inst_q.size() || inst_q[i] !== IDLE_WORD) nbad++;
        checks++; if (nbad != 0) begin errors++; $display("FAIL stall_idle_word: %0d of 5 stall cycles not idle", nbad); end
        checks++; if (done_cyc != 44) begin errors++; $display("FAIL stall_done_cycle: got %0d expected 44", done_cyc); end
        checks++; if (ofrd_cnt != 4) begin errors++; $display("FAIL stall_ofifo_rd: got %0d expected 4", ofrd_cnt); end
        checks++; if (pm_q.size() != 4 || pm_q[0] !== pm_enc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'h200)) begin
            errors++; $display("FAIL stall_pmem_ops: %0d ops, expected 4 starting at 0x200", pm_q.size()); end
    endtask

    task automatic test_zero_and_ignore();
        launch(11'h010, 11'h100, 11'h200, 7'd0, 1'b0);
        run_to_idle(20);
        mon_en = 1'b0;
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
        checks++; if (busy_cnt != 1) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 1", busy_cnt); end
        checks++; if (xrd_q.size() != 0 || pm_q.size() != 0) begin
            errors++; $display("FAIL zero_no_mem_access: xmem %0d pmem %0d accesses, expected 0", xrd_q.size(), pm_q.size()); end

        // start pulses during X_EXEC and during DONE are dropped
        launch(11'h010, 11'h100, 11'h200, 7'd4, 1'b0);
        repeat (31) step();           // cycle 31, X_EXEC
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (7) step();            // cycle 39, DONE
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ignore_done_at_39: done=%b expected 1", bus.done); end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_after_done: busy=%b expected 0", bus.busy); end
        repeat (6) step();
        mon_en = 1'b0;
        checks++; if (done_cnt != 1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL ignore_single_done: done pulses=%0d busy=%b expected 1 and 0", done_cnt, bus.busy); end
    endtask

    task automatic test_reset_abort_wrap();
        logic [ADDR_W-1:0] exp_x[$];
        logic [15:0]       exp_p[$];
        int nbad;
        launch(11'h040, 11'h300, 11'h000, 7'd4, 1'b0);
        repeat (32) step();           // X_EXEC
        reset = 1'b1;
        step();
        reset = 1'b0;
        mon_en = 1'b0;
        checks++; if (bus.inst !== IDLE_WORD || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL abort_idle: inst=%h busy=%b done=%b expected %h 0 0", bus.inst, bus.busy, bus.done, IDLE_WORD); end

        launch(11'h7FC, 11'h7FE, 11'h7FF, 7'd3, 1'b0);
        run_to_idle(100);
        mon_en = 1'b0;
        exp_x = '{11'h7FC, 11'h7FD, 11'h7FE, 11'h7FF, 11'h000, 11'h001, 11'h002, 11'h003,
                  11'h7FE, 11'h7FF, 11'h000};
        exp_p.push_back(pm_enc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'h7FF));
        exp_p.push_back(pm_enc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'h000));
        exp_p.push_back(pm_enc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'h001));
        nbad = 0;
        if (xrd_q.size() != exp_x.size()) nbad++;
        else foreach (exp_x[i]) if (xrd_q[i] !== exp_x[i]) nbad++;
        checks++; if (nbad != 0) begin errors++; $display("FAIL wrap_xmem_addr: %0d reads, %0d wrong, expected 11 reads", xrd_q.size(), nbad); end
        nbad = 0;
        if (pm_q.size() != exp_p.size()) nbad++;
        else foreach (exp_p[i]) if (pm_q[i] !== exp_p[i]) nbad++;
        checks++; if (nbad != 0) begin errors++; $display("FAIL wrap_pmem_ops: %0d ops, %0d wrong, expected 3 ops", pm_q.size(), nbad); end
        checks++; if (done_cyc != 36) begin errors++; $display("FAIL wrap_done_cycle: got %0d expected 36", done_cyc); end
    endtask

    task automatic test_clamp();
        launch(11'h000, 11'h400, 11'h100, 7'd100, 1'b0);
        run_to_idle(400);
        mon_en = 1'b0;
        checks++; if (done_cyc != 219) begin errors++; $display("FAIL clamp_done_cycle: got %0d expected 219", done_cyc); end
        checks++; if (xrd_q.size() != 72) begin errors++; $display("FAIL clamp_xmem_reads: got %0d expected 72", xrd_q.size()); end
        checks++; if (ofrd_cnt != 64) begin errors++; $display("FAIL clamp_ofifo_rd: got %0d expected 64", ofrd_cnt); end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.w_base = '0; bus.x_base = '0; bus.p_base = '0;
        bus.n_vec = '0; bus.accumulate = 1'b0; bus.ofifo_valid = 1'b1;
        mon_clear();
        test_reset();
        test_passthrough();
        test_accumulate();
        test_drain_stall();
        test_zero_and_ignore();
        test_reset_abort_wrap();
        test_clamp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
